fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling FIFO between the instruction-fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Accepts {pc_plus4, instr} pairs from fetch.
- Presents them show-ahead to decode.
- Back-pressures fetch through wr_ready, which drives the fetch-stage en.
- Discards all contents on a branch/jump redirect, so that wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- ADDR_W, 10, width of pc_plus4 (instruction-memory byte address).
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- wr_valid  input  1  fetch presents a valid pair this cycle.
- wr_pc_plus4  input  ADDR_W  pc_plus4 of the fetched instruction.
- wr_instr  input  INSTR_W  fetched instruction word.
- wr_ready  output  1  queue can accept; connects to fetch en.
- rd_valid  output  1  head entry valid.
- rd_pc_plus4  output  ADDR_W  head entry pc_plus4.
- rd_instr  output  INSTR_W  head entry instruction.
- rd_ready  input  1  decode consumes the head this cycle (decode not stalled).
- flush  input  1  redirect; driven by branch_taken | jump.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_valid=0, rd_pc_plus4=0, rd_instr=32'h0000_0000 (NOP, sll $0,$0,0), wr_ready=1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately; no partial push or pop completes.
- Push: occurs on a rising edge when wr_valid && wr_ready && !flush.
  - Writes the pair at wr_ptr; wr_ptr advances by 1 modulo DEPTH.
- Pop: occurs on a rising edge when rd_valid && rd_ready && !flush.
  - rd_ptr advances by 1 modulo DEPTH.
- Count update: count +1 on push only, -1 on pop only, unchanged on both or neither.
- Derived outputs (combinational from registered state):
  - wr_ready = (count != DEPTH). There is no full pass-through: when full, a same-cycle pop does not make wr_ready 1 in that cycle.
  - rd_valid = (count != 0).
  - rd_pc_plus4 / rd_instr = entry at rd_ptr when rd_valid. When empty they read 0 / NOP, so decode sees a bubble.
- Latency:
  - A push into an empty queue is visible at rd_* one cycle after the push edge.
  - There is no combinational path from wr_* to rd_*.
- Flush (synchronous, highest priority after reset):
  - At the edge, count=0 and rd_ptr=wr_ptr; any same-cycle push and pop are discarded.
  - On the next cycle rd_valid=0 and wr_ready=1.
- Simultaneous push+pop:
  - Allowed at any 0<count<DEPTH; count is unchanged and both pointers advance.
  - At count=0 the pop is impossible (rd_valid=0), so only the push occurs.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are decided by count only, never by pointer compare.
- Overflow and underflow are impossible by construction: writes when full and reads when empty are ignored and state is unchanged.
- rd_* outputs must be stable throughout any cycle with rd_valid=1 && rd_ready=0.

Decomposition:
- Shared package pipe_pkg holds:
  - INSTR_NOP = 32'h0000_0000.
  - ADDR_W = 10 and INSTR_W = 32 defaults.
  - typedef fq_entry_t = {pc_plus4[ADDR_W-1:0], instr[INSTR_W-1:0]}.
- One sub-module: fetch_queue_ram.
  - DEPTH x (ADDR_W+INSTR_W) register array.
  - Synchronous write port, asynchronous read port, no reset on the data.
- Pointer, count and flush control live in fetch_queue.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> count=0, rd_valid=0, rd_instr=32'h0, wr_ready=1.
- Fill and stall: push 4 pairs (pc_plus4 0x004/0x008/0x00C/0x010, instr 0x20080001..0x20080004) with rd_ready=0 -> count=4, wr_ready=0; a 5th push (0x014) is ignored; rd_instr remains 0x20080001.
- Drain in order: rd_ready=1 for 4 cycles -> rd_pc_plus4 reads 0x004, 0x008, 0x00C, 0x010 in order; then rd_valid=0 and rd_instr=0.
- Steady streaming with wrap: wr_valid=rd_ready=1 for 10 cycles after one pre-load -> count stays 1, all 10 pairs emerge in order across pointer wrap, with 1-cycle latency.
- Flush mid-stream: count=3, assert flush together with wr_valid=1 and rd_ready=1 -> next cycle count=0, rd_valid=0, wr_ready=1, and the flush-cycle push is absent; the next push (0x100) appears alone.
- Async reset mid-operation: count=2, pull reset low between edges -> count=0 and rd_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
// Holds the default widths, the NOP encoding and the queue entry layout.
package pipe_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 32;

    // sll $0,$0,0: decode treats an empty queue as this bubble.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Queue storage: DEPTH x W registers, written on the clock edge and read combinationally.
// The data is not reset; the control logic only exposes entries that were written.
module fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 42,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead fetch->decode FIFO; a push is visible at rd_* one cycle after its edge.
// wr_ready drops only at full (no same-cycle pass-through); flush empties the queue.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_pc_plus4,
    input  logic [INSTR_W-1:0]       wr_instr,
    output logic                     wr_ready,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_pc_plus4,
    output logic [INSTR_W-1:0]       rd_instr,
    input  logic                     rd_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    import pipe_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int W  = ADDR_W + INSTR_W;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;

    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = rd_valid && rd_ready && !flush;

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .W     (W),
        .PW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({wr_pc_plus4, wr_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Full/empty come from count alone; the pointers are free-running mod DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rd_pc_plus4 = rd_valid ? head[W-1:INSTR_W] : '0;
    assign rd_instr    = rd_valid ? head[INSTR_W-1:0] : INSTR_W'(INSTR_NOP);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences and random traffic
// checked against a queue-based model of the FIFO rules.
module tb_fetch_queue;

    import pipe_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_valid;
    logic [ADDR_W-1:0]   wr_pc_plus4;
    logic [INSTR_W-1:0]  wr_instr;
    logic                wr_ready;
    logic                rd_valid;
    logic [ADDR_W-1:0]   rd_pc_plus4;
    logic [INSTR_W-1:0]  rd_instr;
    logic                rd_ready;
    logic                flush;
    logic [2:0]          count;

    int checks   = 0;
    int failures = 0;

    fq_entry_t model_q[$];

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_pc_plus4 (wr_pc_plus4),
        .wr_instr    (wr_instr),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_pc_plus4 (rd_pc_plus4),
        .rd_instr    (rd_instr),
        .rd_ready    (rd_ready),
        .flush       (flush),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [9:0]  pc;
        logic [31:0] ins;
        logic        rr;
        logic        fl;
        int          e_count;
        logic        e_rd_valid;
        logic        e_wr_ready;
        logic [9:0]  e_pc;
        logic [31:0] e_ins;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [9:0] pc, input logic [31:0] ins,
                         input logic rr, input logic fl);
        wr_valid    = wv;
        wr_pc_plus4 = pc;
        wr_instr    = ins;
        rd_ready    = rr;
        flush       = fl;
    endtask

    // Model: an ordered list of at most DEPTH entries.
    task automatic tick();
        bit do_push, do_pop;
        fq_entry_t e;
        @(posedge clk);
        do_push = wr_valid && (model_q.size() < DEPTH) && !flush;
        do_pop  = rd_ready && (model_q.size() > 0) && !flush;
        e.pc_plus4 = wr_pc_plus4;
        e.instr    = wr_instr;
        if (flush) model_q.delete();
        else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        int n = model_q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(n != DEPTH));
        chk({tag, ".rd_pc"}, 32'(rd_pc_plus4), (n != 0) ? 32'(model_q[0].pc_plus4) : 32'h0);
        chk({tag, ".rd_instr"}, rd_instr, (n != 0) ? model_q[0].instr : INSTR_NOP);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 10'h004, 32'h20080001, 1'b0, 1'b0, 1, 1'b1, 1'b1, 10'h004, 32'h20080001};
        vecs[1] = '{1'b1, 10'h008, 32'h20080002, 1'b0, 1'b0, 2, 1'b1, 1'b1, 10'h004, 32'h20080001};
        vecs[2] = '{1'b1, 10'h00C, 32'h20080003, 1'b0, 1'b0, 3, 1'b1, 1'b1, 10'h004, 32'h20080001};
        vecs[3] = '{1'b1, 10'h010, 32'h20080004, 1'b0, 1'b0, 4, 1'b1, 1'b0, 10'h004, 32'h20080001};
        vecs[4] = '{1'b1, 10'h014, 32'h20080005, 1'b0, 1'b0, 4, 1'b1, 1'b0, 10'h004, 32'h20080001};
        vecs[5] = '{1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 3, 1'b1, 1'b1, 10'h008, 32'h20080002};
        vecs[6] = '{1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 2, 1'b1, 1'b1, 10'h00C, 32'h20080003};
        vecs[7] = '{1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1, 1'b1, 1'b1, 10'h010, 32'h20080004};
        vecs[8] = '{1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 0, 1'b0, 1'b1, 10'h000, 32'h0};
        vecs[9] = '{1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 0, 1'b0, 1'b1, 10'h000, 32'h0};

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.rd_valid", 32'(rd_valid), 32'd0);
        chk("reset.rd_instr", rd_instr, 32'h0);
        chk("reset.rd_pc", 32'(rd_pc_plus4), 32'h0);
        chk("reset.wr_ready", 32'(wr_ready), 32'd1);

        // Fill, stall, ignored 5th push, drain, empty pop.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].wv, vecs[i].pc, vecs[i].ins, vecs[i].rr, vecs[i].fl);
            tick();
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rd_valid));
            chk($sformatf("vec%0d.wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wr_ready));
            chk($sformatf("vec%0d.rd_pc", i), 32'(rd_pc_plus4), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d.rd_instr", i), rd_instr, vecs[i].e_ins);
        end

        // Streaming at count=1 across pointer wrap.
        drive(1'b1, 10'h200, 32'hAA000000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 10'(12'h204 + 4 * i), 32'hAA000001 + 32'(i), 1'b1, 1'b0);
            tick();
            chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
            chk($sformatf("stream%0d.rd_pc", i), 32'(rd_pc_plus4), 32'h204 + 32'(4 * i));
            chk($sformatf("stream%0d.rd_instr", i), rd_instr, 32'hAA000001 + 32'(i));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check_model("stream_end");

        // Flush with concurrent push and pop at count=3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'(10'h040 + 4 * i), 32'hBB000000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("preflush.count", 32'(count), 32'd3);
        drive(1'b1, 10'h0FC, 32'hDEADBEEF, 1'b1, 1'b1);
        tick();
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.rd_valid", 32'(rd_valid), 32'd0);
        chk("flush.wr_ready", 32'(wr_ready), 32'd1);
        drive(1'b1, 10'h100, 32'h12345678, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("postflush.count", 32'(count), 32'd1);
        chk("postflush.rd_pc", 32'(rd_pc_plus4), 32'h100);
        chk("postflush.rd_instr", rd_instr, 32'h12345678);
        tick();
        check_model("postflush_hold");

        // Asynchronous reset between edges at count=2.
        drive(1'b1, 10'h300, 32'hCC000000, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("prearst.count", 32'(count), 32'd2);
        #2 reset = 1'b0;
        #1;
        model_q.delete();
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.rd_valid", 32'(rd_valid), 32'd0);
        chk("arst.wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        check_model("arst_release");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 10'($urandom), 32'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
